ibex_rf_write_arbiter: RTL and testbench

IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

---
 rtl/ibex_wb_pkg.sv | 15 +
 rtl/ibex_rf_write_arbiter_if.sv | 37 +++
 rtl/ibex_wb_fifo.sv | 71 +++++++
 rtl/ibex_rf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_ibex_rf_write_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_wb_pkg.sv
// Shared write-back types for the register-file write arbiter and its result queue.
package ibex_wb_pkg;

  localparam int unsigned WbFifoDepthDefault = 2;

  // Queue entries carry data at this width; arbiter DataWidth must not exceed it.
  localparam int unsigned WbDataWidthMax = 32;

  typedef struct packed {
    logic [4:0]                waddr;
    logic [WbDataWidthMax-1:0] wdata;
    logic                      dummy;
  } wb_entry_t;

endpackage

// File: rtl/ibex_rf_write_arbiter_if.sv
// Write-back bundle: EX result handshake, LSU load response, register-file write port.
interface ibex_rf_write_arbiter_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_dummy_i;

  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;

  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_dummy_o;
  logic [31:0]          pending_o;
  logic                 err_o;

  // Pipeline side: produces results, observes the register-file write.
  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i, ex_dummy_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_dummy_o, pending_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i, ex_dummy_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_dummy_o, pending_o, err_o
  );

endinterface

// File: rtl/ibex_wb_fifo.sv
// EX result queue: circular storage with pointers and count, exposing the head and
// per-entry valid/waddr so the arbiter can build the pending mask and detect stale loads.
module ibex_wb_fifo
  import ibex_wb_pkg::*;
#(
  parameter int unsigned Depth = WbFifoDepthDefault,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CntW-1:0]       count_o,
  output logic [Depth-1:0]      entry_valid_o,
  output logic [Depth-1:0][4:0] entry_waddr_o
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop_i)  rptr_q <= ptr_inc(rptr_q);
      if (push_i && !pop_i) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_entry_i;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < Depth; i++) begin
      off = (i >= 32'(rptr_q)) ? (i - 32'(rptr_q)) : (i + Depth - 32'(rptr_q));
      entry_valid_o[i] = (off < 32'(count_q));
      entry_waddr_o[i] = mem_q[i].waddr;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  count_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && (count_q == CntW'(Depth))));

  count_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && (count_q == '0)));

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write arbiter: merges LSU load responses and queued/bypassed EX results
// onto a single registered write port with fixed one-cycle latency.
module ibex_rf_write_arbiter
  import ibex_wb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = WbFifoDepthDefault
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ibex_rf_write_arbiter_if.slave wb
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [CntW-1:0]           count;
  logic [FifoDepth-1:0]      entry_valid;
  logic [FifoDepth-1:0][4:0] entry_waddr;
  wb_entry_t                 head, ex_entry, sel_entry;
  logic                      empty, ex_accept, push, pop;
  logic                      sel_valid, lsu_drop, lsu_hazard, addr_illegal;
  logic                      we_d, err_d;
  logic [31:0]               pending;

  logic                      rf_we_q, rf_dummy_q, err_q;
  logic [4:0]                rf_waddr_q;
  logic [DataWidth-1:0]      rf_wdata_q;

  ibex_wb_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .push_entry_i  (ex_entry),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (count),
    .entry_valid_o (entry_valid),
    .entry_waddr_o (entry_waddr)
  );

  assign wb.ex_ready_o = (count < CntW'(FifoDepth));
  assign empty         = (count == '0);
  assign ex_accept     = wb.ex_valid_i & wb.ex_ready_o & ~rst_i;
  assign ex_entry      = '{waddr: wb.ex_waddr_i,
                           wdata: WbDataWidthMax'(wb.ex_wdata_i),
                           dummy: wb.ex_dummy_i};

  // Pending mask and stale-load detection: any queued EX write is younger than the load.
  always_comb begin
    pending    = '0;
    lsu_hazard = 1'b0;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      if (entry_valid[i]) begin
        pending[entry_waddr[i]] = 1'b1;
        if (entry_waddr[i] == wb.lsu_waddr_i) lsu_hazard = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  assign wb.pending_o = pending;

  // Priority select: LSU, then queue head, then EX bypass into an empty queue.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    lsu_drop  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (!rst_i) begin
      if (wb.lsu_valid_i) begin
        sel_valid = 1'b1;
        sel_entry = '{waddr: wb.lsu_waddr_i,
                      wdata: WbDataWidthMax'(wb.lsu_wdata_i),
                      dummy: 1'b0};
        lsu_drop  = lsu_hazard;
        push      = ex_accept;
      end else if (!empty) begin
        sel_valid = 1'b1;
        sel_entry = head;
        pop       = 1'b1;
        push      = ex_accept;
      end else if (ex_accept) begin
        sel_valid = 1'b1;
        sel_entry = ex_entry;
      end
    end
  end

  assign addr_illegal = RV32E & sel_entry.waddr[4];
  assign we_d  = sel_valid & ~lsu_drop & ~addr_illegal & (sel_entry.waddr != 5'd0);
  assign err_d = sel_valid & addr_illegal;

  // Registered write port and error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_dummy_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= we_d;
      rf_waddr_q <= sel_entry.waddr;
      rf_wdata_q <= sel_entry.wdata[DataWidth-1:0];
      rf_dummy_q <= sel_valid & sel_entry.dummy;
      err_q      <= err_d;
    end
  end

  assign wb.rf_we_o    = rf_we_q;
  assign wb.rf_waddr_o = rf_waddr_q;
  assign wb.rf_wdata_o = rf_wdata_q;
  assign wb.rf_dummy_o = rf_dummy_q;
  assign wb.err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for the write arbiter: an RV32I and an RV32E instance driven identically and
// compared against a queue-based model of the write-back ordering rules.
module tb_ibex_rf_write_arbiter;

  localparam int Depth = 2;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          dummy;
  } ent_t;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;
  ent_t q[$];

  ibex_rf_write_arbiter_if #(.DataWidth(32)) ifa ();
  ibex_rf_write_arbiter_if #(.DataWidth(32)) ifb ();

  ibex_rf_write_arbiter #(
    .RV32E     (1'b0),
    .DataWidth (32),
    .FifoDepth (Depth)
  ) u_dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (ifa)
  );

  ibex_rf_write_arbiter #(
    .RV32E     (1'b1),
    .DataWidth (32),
    .FifoDepth (Depth)
  ) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) p[q[i].waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, advance the model,
  // then check the registered write port just after the rising edge.
  task automatic step(input bit r, input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                      input bit edm, input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit   rdy, acc, sel, haz, we0, we1, err1;
    ent_t e;
    rst             = r;
    ifa.ex_valid_i  = ev;  ifb.ex_valid_i  = ev;
    ifa.ex_waddr_i  = ea;  ifb.ex_waddr_i  = ea;
    ifa.ex_wdata_i  = ed;  ifb.ex_wdata_i  = ed;
    ifa.ex_dummy_i  = edm; ifb.ex_dummy_i  = edm;
    ifa.lsu_valid_i = lv;  ifb.lsu_valid_i = lv;
    ifa.lsu_waddr_i = la;  ifb.lsu_waddr_i = la;
    ifa.lsu_wdata_i = ld;  ifb.lsu_wdata_i = ld;
    #1;
    rdy = (q.size() < Depth);
    check_eq("ready0", ifa.ex_ready_o, rdy);
    check_eq("ready1", ifb.ex_ready_o, rdy);
    check_eq("pend0", ifa.pending_o, model_pending());
    check_eq("pend1", ifb.pending_o, model_pending());
    sel = 0;
    haz = 0;
    e   = '{waddr: 5'd0, wdata: 32'd0, dummy: 1'b0};
    if (r) begin
      q.delete();
    end else begin
      acc = ev && rdy;
      if (lv) begin
        sel = 1;
        e   = '{waddr: la, wdata: ld, dummy: 1'b0};
        foreach (q[i]) if (q[i].waddr == la) haz = 1;
        if (acc) q.push_back('{waddr: ea, wdata: ed, dummy: edm});
      end else if (q.size() > 0) begin
        sel = 1;
        e   = q.pop_front();
        if (acc) q.push_back('{waddr: ea, wdata: ed, dummy: edm});
      end else if (acc) begin
        sel = 1;
        e   = '{waddr: ea, wdata: ed, dummy: edm};
      end
    end
    we0  = sel && !haz && (e.waddr != 5'd0);
    we1  = we0 && !e.waddr[4];
    err1 = sel && e.waddr[4];
    @(posedge clk);
    #1;
    check_eq("we0", ifa.rf_we_o, we0);
    check_eq("we1", ifb.rf_we_o, we1);
    check_eq("err0", ifa.err_o, 0);
    check_eq("err1", ifb.err_o, err1);
    if (we0) begin
      check_eq("waddr0", ifa.rf_waddr_o, e.waddr);
      check_eq("wdata0", ifa.rf_wdata_o, e.wdata);
      check_eq("dummy0", ifa.rf_dummy_o, e.dummy);
    end
    if (we1) begin
      check_eq("waddr1", ifb.rf_waddr_o, e.waddr);
      check_eq("wdata1", ifb.rf_wdata_o, e.wdata);
      check_eq("dummy1", ifb.rf_dummy_o, e.dummy);
    end
    if (r) begin
      check_eq("rst_waddr", ifa.rf_waddr_o, 0);
      check_eq("rst_wdata", ifa.rf_wdata_o, 0);
      check_eq("rst_dummy", ifa.rf_dummy_o, 0);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    ifa.ex_valid_i  = 0; ifb.ex_valid_i  = 0;
    ifa.ex_waddr_i  = 0; ifb.ex_waddr_i  = 0;
    ifa.ex_wdata_i  = 0; ifb.ex_wdata_i  = 0;
    ifa.ex_dummy_i  = 0; ifb.ex_dummy_i  = 0;
    ifa.lsu_valid_i = 0; ifb.lsu_valid_i = 0;
    ifa.lsu_waddr_i = 0; ifb.lsu_waddr_i = 0;
    ifa.lsu_wdata_i = 0; ifb.lsu_wdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("init_we", ifa.rf_we_o, 0);
    check_eq("init_err", ifb.err_o, 0);
    check_eq("init_waddr", ifa.rf_waddr_o, 0);
    check_eq("init_wdata", ifa.rf_wdata_o, 0);
    check_eq("init_pend", ifa.pending_o, 0);
    check_eq("init_ready", ifa.ex_ready_o, 1);

    // Bypass into an idle queue.
    step(0, 1, 5'd5, 32'hA5A5A5A5, 0, 0, 5'd0, 32'd0);
    check_eq("bypass_we", ifa.rf_we_o, 1);
    check_eq("bypass_waddr", ifa.rf_waddr_o, 5);
    check_eq("bypass_wdata", ifa.rf_wdata_o, 32'hA5A5A5A5);
    check_eq("bypass_pend", ifa.pending_o, 0);
    idle();

    // LSU wins, EX queued behind it.
    step(0, 1, 5'd7, 32'h77, 1, 1, 5'd3, 32'h33);
    check_eq("lsufirst_waddr", ifa.rf_waddr_o, 3);
    check_eq("lsufirst_dummy", ifa.rf_dummy_o, 0);
    check_eq("lsufirst_pend7", ifa.pending_o[7], 1);
    idle();
    check_eq("exsecond_waddr", ifa.rf_waddr_o, 7);
    check_eq("exsecond_dummy", ifa.rf_dummy_o, 1);
    check_eq("exsecond_pend", ifa.pending_o, 0);

    // Back-pressure: three LSU cycles against continuous EX offers.
    step(0, 1, 5'd11, 32'h1111, 0, 1, 5'd10, 32'h1010);
    step(0, 1, 5'd13, 32'h1313, 0, 1, 5'd12, 32'h1212);
    check_eq("full_ready", ifa.ex_ready_o, 0);
    step(0, 1, 5'd15, 32'h1515, 0, 1, 5'd14, 32'h1414);
    idle();
    check_eq("drain_first", ifa.rf_waddr_o, 11);
    idle();
    check_eq("drain_second", ifa.rf_waddr_o, 13);
    idle();

    // Stale load to a register with a queued EX write.
    step(0, 1, 5'd9, 32'h9999, 0, 1, 5'd20, 32'h2020);
    step(0, 0, 5'd0, 32'd0, 0, 1, 5'd9, 32'hDEAD);
    check_eq("stale_we", ifa.rf_we_o, 0);
    idle();
    check_eq("stale_ex_waddr", ifa.rf_waddr_o, 9);
    check_eq("stale_ex_wdata", ifa.rf_wdata_o, 32'h9999);

    // RV32E illegal address pulse, then x0.
    step(0, 1, 5'd17, 32'h1717, 0, 0, 5'd0, 32'd0);
    check_eq("e_we", ifb.rf_we_o, 0);
    check_eq("e_err", ifb.err_o, 1);
    idle();
    check_eq("e_err_pulse", ifb.err_o, 0);
    step(0, 1, 5'd0, 32'h1234, 0, 0, 5'd0, 32'd0);
    check_eq("x0_we", ifb.rf_we_o, 0);
    check_eq("x0_err", ifb.err_o, 0);

    // Reset with two entries queued; inputs during reset are ignored.
    step(0, 1, 5'd2, 32'h22, 0, 1, 5'd1, 32'h11);
    step(0, 1, 5'd4, 32'h44, 0, 1, 5'd3, 32'h33);
    step(1, 1, 5'd5, 32'h55, 0, 1, 5'd6, 32'h66);
    check_eq("rst_we", ifa.rf_we_o, 0);
    check_eq("rst_pend", ifa.pending_o, 0);
    check_eq("rst_ready", ifa.ex_ready_o, 1);
    repeat (3) idle();

    // Randomized traffic, with loads often aimed at queued registers.
    for (int n = 0; n < 3000; n++) begin
      bit          r, ev, lv, edm;
      logic [4:0]  ea, la;
      logic [31:0] ed, ld;
      r   = ($urandom_range(0, 99) == 0);
      ev  = ($urandom_range(0, 9) < 7);
      lv  = ($urandom_range(0, 9) < 4);
      edm = $urandom_range(0, 1);
      ea  = 5'($urandom_range(0, 31));
      la  = 5'($urandom_range(0, 31));
      if (q.size() > 0 && $urandom_range(0, 2) == 0) la = q[$urandom_range(0, q.size() - 1)].waddr;
      ed  = $urandom;
      ld  = $urandom;
      step(r, ev, ea, ed, edm, lv, la, ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
